// File: rtl/lap_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lap_buffer_pkg
// Brief    : Shared state encoding and lap-entry width for the lap buffer.
// Revision : 1.0 - initial release
// ============================================================================
package lap_buffer_pkg;

  // One lap entry is the four MM:SS BCD digits {mt,mo,st,so}.
  localparam int LAP_W = 16;

  // Display-path state.
  typedef enum logic [1:0] {
    ST_LIVE   = 2'd0,
    ST_FREEZE = 2'd1,
    ST_RECALL = 2'd2
  } lap_state_e;

endpackage : lap_buffer_pkg
`default_nettype wire

// File: rtl/lap_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module   : lap_ram
// Brief    : DEPTH x LAP_W register array with synchronous write and
//            combinational read. It has no reset, so it can map to
//            distributed RAM.
// Revision : 1.0 - initial release
// ============================================================================
module lap_ram
  import lap_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [LAP_W-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [LAP_W-1:0] rdata
);

  logic [LAP_W-1:0] r_mem [DEPTH];

  // Write port: store one captured lap.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : lap_ram
`default_nettype wire

// File: rtl/lap_buffer.sv
`default_nettype none
// ============================================================================
// Module   : lap_buffer
// Brief    : Lap/split capture stage. It captures MM:SS into a circular
//            buffer and freezes the display for HOLD_TICKS seconds. It also
//            replays the stored laps oldest-first and otherwise passes the
//            live time through.
// Revision : 1.0 - initial release
// ============================================================================
module lap_buffer
  import lap_buffer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2,
  parameter int HOLD_TICKS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             lap_pulse,
  input  logic             recall_pulse,
  input  logic             clear_pulse,
  input  logic [3:0]       live_mt,
  input  logic [3:0]       live_mo,
  input  logic [3:0]       live_st,
  input  logic [3:0]       live_so,
  output logic [3:0]       disp_mt,
  output logic [3:0]       disp_mo,
  output logic [3:0]       disp_st,
  output logic [3:0]       disp_so,
  output logic             frozen,
  output logic [PTR_W:0]   lap_count,
  output logic [PTR_W-1:0] recall_idx,
  output logic             overflow
);

  localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
  localparam logic [3:0]       C_HOLD    = 4'(HOLD_TICKS);

  lap_state_e       r_state, w_state_nxt;
  logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [PTR_W:0]   r_lap_count, w_lap_count_nxt;
  logic [3:0]       r_hold_cnt, w_hold_cnt_nxt;
  logic [PTR_W-1:0] r_recall_idx, w_recall_idx_nxt;
  logic             r_overflow, w_overflow_nxt;
  logic [LAP_W-1:0] r_disp, w_disp_nxt;
  logic             r_frozen;

  logic             w_we;
  logic [LAP_W-1:0] w_live;
  logic [PTR_W-1:0] w_oldest;
  logic [PTR_W-1:0] w_rd_addr;
  logic [LAP_W-1:0] w_rd_data;

  assign w_live = {live_mt, live_mo, live_st, live_so};

  // When the buffer is full, the low bits of lap_count are zero, so the
  // oldest entry is the one at wr_ptr.
  assign w_oldest = r_wr_ptr - r_lap_count[PTR_W-1:0];

  // Entering RECALL shows the oldest entry. Stepping inside RECALL shows the
  // entry after the current index. The wrap case does not use the read data.
  assign w_rd_addr = (r_state == ST_RECALL) ? (w_oldest + r_recall_idx + C_PTR_ONE)
                                            : w_oldest;

  lap_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_lap_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (w_live),
    .raddr (w_rd_addr),
    .rdata (w_rd_data)
  );

  // Next-state and next-output logic; priority is clear > lap > recall > tick.
  always_comb begin
    w_state_nxt      = r_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_lap_count_nxt  = r_lap_count;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_recall_idx_nxt = r_recall_idx;
    w_overflow_nxt   = r_overflow;
    w_disp_nxt       = r_disp;
    w_we             = 1'b0;

    if (clear_pulse) begin
      w_state_nxt      = ST_LIVE;
      w_wr_ptr_nxt     = '0;
      w_lap_count_nxt  = '0;
      w_hold_cnt_nxt   = '0;
      w_recall_idx_nxt = '0;
      w_overflow_nxt   = 1'b0;
      w_disp_nxt       = w_live;
    end else if (lap_pulse) begin
      w_we             = 1'b1;
      w_wr_ptr_nxt     = r_wr_ptr + C_PTR_ONE;
      w_recall_idx_nxt = '0;
      w_disp_nxt       = w_live;
      if (r_lap_count == C_FULL) begin
        w_overflow_nxt = 1'b1;
      end else begin
        w_lap_count_nxt = r_lap_count + C_CNT_ONE;
      end
      if (HOLD_TICKS > 0) begin
        w_state_nxt    = ST_FREEZE;
        w_hold_cnt_nxt = C_HOLD;
      end else begin
        w_state_nxt    = ST_LIVE;
        w_hold_cnt_nxt = '0;
      end
    end else if (recall_pulse && (r_lap_count != '0)) begin
      w_hold_cnt_nxt = '0;
      if (r_state != ST_RECALL) begin
        w_state_nxt      = ST_RECALL;
        w_recall_idx_nxt = '0;
        w_disp_nxt       = w_rd_data;
      end else if ({1'b0, r_recall_idx} < (r_lap_count - C_CNT_ONE)) begin
        w_recall_idx_nxt = r_recall_idx + C_PTR_ONE;
        w_disp_nxt       = w_rd_data;
      end else begin
        w_state_nxt      = ST_LIVE;
        w_recall_idx_nxt = '0;
        w_disp_nxt       = w_live;
      end
    end else if ((r_state == ST_FREEZE) && tick_1hz) begin
      if (r_hold_cnt <= 4'd1) begin
        w_state_nxt    = ST_LIVE;
        w_hold_cnt_nxt = '0;
        w_disp_nxt     = w_live;
      end else begin
        w_hold_cnt_nxt = r_hold_cnt - 4'd1;
      end
    end else if (r_state == ST_LIVE) begin
      w_disp_nxt = w_live;
    end
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_LIVE;
      r_wr_ptr     <= '0;
      r_lap_count  <= '0;
      r_hold_cnt   <= '0;
      r_recall_idx <= '0;
      r_overflow   <= 1'b0;
      r_disp       <= '0;
      r_frozen     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_lap_count  <= w_lap_count_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_recall_idx <= w_recall_idx_nxt;
      r_overflow   <= w_overflow_nxt;
      r_disp       <= w_disp_nxt;
      r_frozen     <= (w_state_nxt != ST_LIVE);
    end
  end

  assign disp_mt    = r_disp[15:12];
  assign disp_mo    = r_disp[11:8];
  assign disp_st    = r_disp[7:4];
  assign disp_so    = r_disp[3:0];
  assign frozen     = r_frozen;
  assign lap_count  = r_lap_count;
  assign recall_idx = r_recall_idx;
  assign overflow   = r_overflow;

endmodule : lap_buffer
`default_nettype wire

// File: tb/tb_lap_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lap_buffer
// Brief    : Scoreboard bench for lap_buffer with a queue-based lap model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lap_buffer;

  localparam int DEPTH      = 4;
  localparam int PTR_W      = 2;
  localparam int HOLD_TICKS = 3;

  typedef struct packed {
    logic [15:0]    disp;
    logic           frozen;
    logic [PTR_W:0] cnt;
    logic [PTR_W-1:0] idx;
    logic           ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_1hz = 1'b0, lap_pulse = 1'b0, recall_pulse = 1'b0, clear_pulse = 1'b0;
  logic [3:0] live_mt = '0, live_mo = '0, live_st = '0, live_so = '0;
  logic [3:0] disp_mt, disp_mo, disp_st, disp_so;
  logic frozen, overflow;
  logic [PTR_W:0] lap_count;
  logic [PTR_W-1:0] recall_idx;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  // Reference model state: the laps are held oldest-first in a queue.
  logic [15:0] m_laps[$];
  int          m_mode;   // 0 live, 1 frozen after capture, 2 replaying laps
  int          m_hold;
  int          m_idx;
  bit          m_ovf;
  logic [15:0] m_disp;

  lap_buffer #(
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .lap_pulse    (lap_pulse),
    .recall_pulse (recall_pulse),
    .clear_pulse  (clear_pulse),
    .live_mt      (live_mt),
    .live_mo      (live_mo),
    .live_st      (live_st),
    .live_so      (live_so),
    .disp_mt      (disp_mt),
    .disp_mo      (disp_mo),
    .disp_st      (disp_st),
    .disp_so      (disp_so),
    .frozen       (frozen),
    .lap_count    (lap_count),
    .recall_idx   (recall_idx),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_view();
    exp_t e;
    e.disp   = m_disp;
    e.frozen = (m_mode != 0);
    e.cnt    = (PTR_W+1)'(m_laps.size());
    e.idx    = PTR_W'(m_idx);
    e.ovf    = m_ovf;
    return e;
  endfunction

  task automatic model_reset();
    m_laps.delete();
    m_mode = 0;
    m_hold = 0;
    m_idx  = 0;
    m_ovf  = 1'b0;
    m_disp = '0;
  endtask

  // Apply one cycle of stimulus, advance the model and queue its prediction.
  task automatic step(input bit lap, input bit rec, input bit clr, input bit tick,
                      input logic [15:0] live);
    @(negedge clk);
    rst_n = 1'b1;
    lap_pulse = lap; recall_pulse = rec; clear_pulse = clr; tick_1hz = tick;
    {live_mt, live_mo, live_st, live_so} = live;
    if (clr) begin
      m_laps.delete(); m_ovf = 1'b0; m_idx = 0; m_mode = 0; m_hold = 0; m_disp = live;
    end else if (lap) begin
      m_laps.push_back(live);
      if (m_laps.size() > DEPTH) begin
        void'(m_laps.pop_front());
        m_ovf = 1'b1;
      end
      m_disp = live; m_idx = 0;
      if (HOLD_TICKS > 0) begin m_mode = 1; m_hold = HOLD_TICKS; end
      else begin m_mode = 0; m_hold = 0; end
    end else if (rec && m_laps.size() > 0) begin
      m_hold = 0;
      if (m_mode != 2) begin
        m_mode = 2; m_idx = 0; m_disp = m_laps[0];
      end else if (m_idx < m_laps.size() - 1) begin
        m_idx++; m_disp = m_laps[m_idx];
      end else begin
        m_mode = 0; m_idx = 0; m_disp = live;
      end
    end else if (m_mode == 1 && tick) begin
      m_hold--;
      if (m_hold == 0) begin m_mode = 0; m_disp = live; end
    end else if (m_mode == 0) begin
      m_disp = live;
    end
    exp_q.push_back(model_view());
  endtask

  function automatic logic [15:0] rand_live();
    return {4'($urandom_range(5)), 4'($urandom_range(9)),
            4'($urandom_range(5)), 4'($urandom_range(9))};
  endfunction

  // Assert reset between clock edges and check that the outputs clear at once.
  task automatic async_reset();
    @(negedge clk);
    lap_pulse = 0; recall_pulse = 0; clear_pulse = 0; tick_1hz = 0;
    {live_mt, live_mo, live_st, live_so} = '0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({disp_mt, disp_mo, disp_st, disp_so} != 16'h0 || frozen || lap_count != 0 ||
        recall_idx != 0 || overflow) begin
      miscompares++;
      $display("FAIL async_reset: got disp=%h fz=%b cnt=%0d idx=%0d ovf=%b, want all zero",
               {disp_mt, disp_mo, disp_st, disp_so}, frozen, lap_count, recall_idx, overflow);
    end
    model_reset();
    exp_q.push_back(model_view());
  endtask

  // Monitor: compare every registered output sample against the next prediction.
  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.disp = {disp_mt, disp_mo, disp_st, disp_so};
      a.frozen = frozen; a.cnt = lap_count; a.idx = recall_idx; a.ovf = overflow;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d @%0t: got disp=%h fz=%b cnt=%0d idx=%0d ovf=%b, want disp=%h fz=%b cnt=%0d idx=%0d ovf=%b",
                 vectors, $time, a.disp, a.frozen, a.cnt, a.idx, a.ovf,
                 e.disp, e.frozen, e.cnt, e.idx, e.ovf);
      end
    end
  end

  initial begin
    model_reset();
    async_reset();

    // Live pass-through.
    step(0, 0, 0, 0, 16'h1234);
    step(0, 0, 0, 0, 16'h1234);

    // Capture 0:05 and hold across three ticks while live moves on.
    step(1, 0, 0, 0, 16'h0005);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 16'h0009);
      step(0, 0, 0, 1, 16'h0009);
    end
    step(0, 0, 0, 0, 16'h0010);

    // Five laps into four entries, then replay and wrap.
    step(0, 0, 1, 0, 16'h0000);
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 16'(i));
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 16'h0100);
    step(0, 0, 0, 0, 16'h0101);

    // Lap and recall together with two stored laps.
    step(0, 0, 1, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0011);
    step(1, 0, 0, 0, 16'h0022);
    step(1, 1, 0, 0, 16'h0033);
    step(0, 0, 0, 1, 16'h0034);

    // Clear plus lap while replaying at index 1.
    step(0, 1, 0, 0, 16'h0040);
    step(0, 1, 0, 0, 16'h0041);
    step(1, 0, 1, 0, 16'h0042);
    step(0, 0, 0, 0, 16'h0043);

    // Recall with an empty buffer.
    step(0, 1, 0, 0, 16'h0050);
    step(0, 0, 0, 1, 16'h0051);

    // Reset in the middle of a freeze.
    step(1, 0, 0, 0, 16'h0060);
    step(0, 0, 0, 1, 16'h0061);
    async_reset();
    step(0, 0, 0, 0, 16'h0000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(7) == 0, $urandom_range(4) == 0, $urandom_range(59) == 0,
           $urandom_range(3) == 0, rand_live());
      if ($urandom_range(999) == 0) async_reset();
    end

    step(0, 0, 0, 0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_lap_buffer
`default_nettype wire
